// File: rtl/mono_pixel_store.sv
// 1-bit-per-pixel frame store feeding VGA scan-out: registered colour lookup on the read side,
// single-pixel valid/ready writes and a full-frame clear engine on the write side.
module mono_pixel_store #(
    parameter int          WIDTH          = 640,
    parameter int          HEIGHT         = 480,
    parameter logic [23:0] FG_RGB         = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB         = 24'h000000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk50,
    input  logic                      reset,
    input  logic [$clog2(WIDTH)-1:0]  wr_x,
    input  logic [$clog2(HEIGHT)-1:0] wr_y,
    input  logic                      wr_color,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      clear_req,
    input  logic                      clear_color,
    output logic                      busy,
    input  logic [$clog2(WIDTH)-1:0]  rd_x,
    input  logic [$clog2(HEIGHT)-1:0] rd_y,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LINE_LEN  = AW'(WIDTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] clr_addr;
    logic          clr_color_q;
    logic [23:0]   rgb_q;
    logic          mem [DEPTH];

    logic          wr_in_range, rd_in_range;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic          mem_wdata;

    // Range checks are done one bit wider so WIDTH/HEIGHT themselves are representable.
    assign wr_in_range = ({1'b0, wr_x} < (XW + 1)'(WIDTH)) && ({1'b0, wr_y} < (YW + 1)'(HEIGHT));
    assign rd_in_range = ({1'b0, rd_x} < (XW + 1)'(WIDTH)) && ({1'b0, rd_y} < (YW + 1)'(HEIGHT));
    assign wr_addr     = AW'(wr_y) * LINE_LEN + AW'(wr_x);
    assign rd_addr     = AW'(rd_y) * LINE_LEN + AW'(rd_x);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            wr_ready    <= 1'b0;
            clr_addr    <= '0;
            clr_color_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // IDLE with wr_ready low only happens on the first cycle out of reset.
                    if (!wr_ready) begin
                        if (CLEAR_ON_RESET) begin
                            state       <= CLEAR;
                            busy        <= 1'b1;
                            clr_color_q <= 1'b0;
                            clr_addr    <= '0;
                        end else begin
                            wr_ready <= 1'b1;
                        end
                    end else if (clear_req) begin
                        state       <= CLEAR;
                        busy        <= 1'b1;
                        wr_ready    <= 1'b0;
                        clr_color_q <= clear_color;
                        clr_addr    <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_color;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = clr_color_q;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            mem_we = 1'b1;
        end
        if (reset) mem_we = 1'b0;
    end

    // NOTE: the pixel array has no reset so it can map onto block RAM; only control state is reset.
    always_ff @(posedge clk50) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Reading before the same-edge write lands gives old data on an address collision.
    always_ff @(posedge clk50) begin
        if (reset)            rgb_q <= '0;
        else if (rd_in_range) rgb_q <= mem[rd_addr] ? FG_RGB : BG_RGB;
        else                  rgb_q <= BG_RGB;
    end

    assign {r, g, b} = rgb_q;

endmodule

// File: tb/tb_mono_pixel_store.sv
// Bench for mono_pixel_store: randomized traffic against a time-stamped pixel model on a 16x8 store,
// plus directed range checks on a 12x6 store without auto-clear.
module tb_mono_pixel_store;
    localparam int W  = 16, H = 8, D = W * H;
    localparam int XW = $clog2(W), YW = $clog2(H);
    localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h000000;
    localparam int W2 = 12, H2 = 6, D2 = W2 * H2;
    localparam int XW2 = $clog2(W2), YW2 = $clog2(H2);
    localparam logic [23:0] FG2 = 24'h12AB34, BG2 = 24'h050607;

    logic clk50, reset;
    logic [XW-1:0] wr_x, rd_x;
    logic [YW-1:0] wr_y, rd_y;
    logic wr_color, wr_valid, wr_ready, clear_req, clear_color, busy;
    logic [7:0] r, g, b;

    logic [XW2-1:0] s2_wr_x, s2_rd_x;
    logic [YW2-1:0] s2_wr_y, s2_rd_y;
    logic s2_wr_color, s2_wr_valid, s2_wr_ready, s2_clear_req, s2_clear_color, s2_busy;
    logic [7:0] s2_r, s2_g, s2_b;

    int n_checks = 0, n_fail = 0;
    bit rd_manual = 0;

    mono_pixel_store #(.WIDTH(W), .HEIGHT(H), .FG_RGB(FG), .BG_RGB(BG), .CLEAR_ON_RESET(1'b1)) dut (
        .clk50(clk50), .reset(reset), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .clear_req(clear_req), .clear_color(clear_color),
        .busy(busy), .rd_x(rd_x), .rd_y(rd_y), .r(r), .g(g), .b(b));

    mono_pixel_store #(.WIDTH(W2), .HEIGHT(H2), .FG_RGB(FG2), .BG_RGB(BG2), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk50(clk50), .reset(reset), .wr_x(s2_wr_x), .wr_y(s2_wr_y), .wr_color(s2_wr_color),
        .wr_valid(s2_wr_valid), .wr_ready(s2_wr_ready), .clear_req(s2_clear_req),
        .clear_color(s2_clear_color), .busy(s2_busy), .rd_x(s2_rd_x), .rd_y(s2_rd_y),
        .r(s2_r), .g(s2_g), .b(s2_b));

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model of the 16x8 store: each pixel holds its last drawn value and the edge it was drawn on;
    // a clear started at edge S paints address a at edge S+1+a unless aborted first.
    bit   pix [D];
    int   wtime [D];
    int   cyc = 0, clr_start = 0, rd_a, wr_a;
    bit   clr_on = 0, clr_col = 0, boot = 0, model_live = 0, acc;
    bit   exp_busy = 0, exp_ready = 0, exp_known = 0;
    logic [23:0] exp_rgb = '0;

    initial for (int i = 0; i < D; i++) wtime[i] = -1;

    function automatic bit painted(input int a, input int t);
        int tc;
        tc = clr_start + 1 + a;
        return clr_on && tc < t && tc > wtime[a];
    endfunction

    task automatic fold_clear(input int t);
        for (int a = 0; a < D; a++)
            if (painted(a, t)) begin
                pix[a]   = clr_col;
                wtime[a] = clr_start + 1 + a;
            end
        clr_on = 0;
    endtask

    always @(posedge clk50) begin
        cyc++;
        rd_a = int'(rd_y) * W + int'(rd_x);
        wr_a = int'(wr_y) * W + int'(wr_x);
        exp_known = 1;
        if (reset)                 exp_rgb = '0;
        else if (painted(rd_a, cyc)) exp_rgb = clr_col ? FG : BG;
        else if (wtime[rd_a] >= 0) exp_rgb = pix[rd_a] ? FG : BG;
        else                       exp_known = 0;

        if (reset) begin
            fold_clear(cyc);
            boot = 1; exp_busy = 0; exp_ready = 0; model_live = 1;
        end else if (boot) begin
            boot = 0; clr_on = 1; clr_start = cyc; clr_col = 0;
            exp_busy = 1; exp_ready = 0;
        end else begin
            acc = exp_ready;
            if (acc && wr_valid) begin
                pix[wr_a]   = wr_color;
                wtime[wr_a] = cyc;
            end
            if (acc && clear_req) begin
                fold_clear(cyc);
                clr_on = 1; clr_start = cyc; clr_col = clear_color;
            end
            exp_busy  = clr_on && (cyc - clr_start) < D;
            exp_ready = !exp_busy;
        end
    end

    always @(negedge clk50) begin
        if (model_live) begin
            check("busy", busy, exp_busy);
            check("wr_ready", wr_ready, exp_ready);
            if (exp_known) check("rgb", {r, g, b}, exp_rgb);
        end
    end

    task automatic step();
        @(negedge clk50);
        if (!rd_manual) begin
            rd_x = XW'($urandom);
            rd_y = YW'($urandom);
        end
    endtask

    task automatic peek(input int x, input int y, output logic [23:0] v);
        rd_manual = 1;
        step();
        rd_x = XW'(x); rd_y = YW'(y);
        step();
        v = {r, g, b};
        rd_manual = 0;
    endtask

    task automatic peek2(input int x, input int y, output logic [23:0] v);
        step();
        s2_rd_x = XW2'(x); s2_rd_y = YW2'(y);
        step();
        v = {s2_r, s2_g, s2_b};
    endtask

    // Counts busy cycles until the store goes idle; optionally re-pulses clear_req mid-clear.
    task automatic wait_idle(input int reinject, output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            wr_valid = 0;
            clear_req = 0;
            if (!busy) break;
            cnt++;
            if (i == reinject) begin
                clear_req = 1; clear_color = ~clear_color;
            end
        end
        clear_req = 0;
    endtask

    initial begin
        #(20000 * 20);
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [23:0] v;
        int xs [4] = '{12, 15, 0, 3};
        int ys [4] = '{0, 5, 6, 7};

        reset = 1; wr_x = '0; wr_y = '0; wr_color = 0; wr_valid = 0;
        clear_req = 0; clear_color = 0; rd_x = '0; rd_y = '0;
        s2_wr_x = '0; s2_wr_y = '0; s2_wr_color = 0; s2_wr_valid = 0;
        s2_clear_req = 0; s2_clear_color = 0; s2_rd_x = '0; s2_rd_y = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rgb", {r, g, b}, 24'h000000);
        check("rst_rgb_d2", {s2_r, s2_g, s2_b}, 24'h000000);

        reset = 0;
        wait_idle(-1, cnt);
        check("boot_busy_cycles", cnt, 128);
        check("boot_ready_after", wr_ready, 1);
        for (int a = 0; a < D; a++) begin
            peek(a % W, a / W, v);
            check("boot_clear_px", v, BG);
        end

        wr_x = 3; wr_y = 2; wr_color = 1; wr_valid = 1;
        check("wr_ready_idle", wr_ready, 1);
        step();
        wr_valid = 0;
        peek(3, 2, v); check("px_3_2_set", v, FG);
        peek(4, 2, v); check("px_4_2_clear", v, BG);

        rd_manual = 1;
        rd_x = 6; rd_y = 1; wr_x = 6; wr_y = 1; wr_color = 1; wr_valid = 1;
        step();
        wr_valid = 0;
        check("rdw_same_addr_old", {r, g, b}, BG);
        step();
        check("rdw_next_new", {r, g, b}, FG);
        rd_manual = 0;

        wr_x = 5; wr_y = 5; wr_color = 1; wr_valid = 1; clear_req = 1; clear_color = 0;
        wait_idle(-1, cnt);
        check("wr_plus_clear_busy", cnt, 128);
        peek(5, 5, v); check("px_5_5_overwritten", v, BG);
        peek(3, 2, v); check("px_3_2_cleared", v, BG);

        clear_req = 1; clear_color = 1;
        wait_idle(10, cnt);
        check("reinject_busy", cnt, 128);
        peek(5, 5, v); check("clear1_px_5_5", v, FG);
        peek(15, 7, v); check("clear1_px_last", v, FG);

        for (int i = 0; i < 600; i++) begin
            step();
            wr_x = XW'($urandom); wr_y = YW'($urandom); wr_color = 1'($urandom);
            wr_valid = 1'($urandom);
            clear_req = ($urandom_range(0, 149) == 0);
            clear_color = 1'($urandom);
        end
        wait_idle(-1, cnt);

        clear_req = 1; clear_color = 1;
        step();
        clear_req = 0;
        repeat (40) step();
        check("midclear_busy", busy, 1);
        reset = 1;
        step();
        check("midclear_rst_busy", busy, 0);
        check("midclear_rst_ready", wr_ready, 0);
        step();
        reset = 0;
        wait_idle(-1, cnt);
        check("reboot_busy_cycles", cnt, 128);
        for (int a = 0; a < D; a++) begin
            peek(a % W, a / W, v);
            check("reboot_px", v, BG);
        end

        step();
        check("d2_idle_ready", s2_wr_ready, 1);
        check("d2_idle_busy", s2_busy, 0);
        s2_clear_req = 1; s2_clear_color = 1;
        step();
        s2_clear_req = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!s2_busy) break;
            cnt++;
            step();
        end
        check("d2_clear_cycles", cnt, D2);
        for (int a = 0; a < D2; a++) begin
            peek2(a % W2, a / W2, v);
            check("d2_fg_px", v, FG2);
        end
        for (int k = 0; k < 4; k++) begin
            s2_wr_x = XW2'(xs[k]); s2_wr_y = YW2'(ys[k]); s2_wr_color = 0; s2_wr_valid = 1;
            check("d2_oor_ready", s2_wr_ready, 1);
            step();
            s2_wr_valid = 0;
        end
        for (int a = 0; a < D2; a++) begin
            peek2(a % W2, a / W2, v);
            check("d2_oor_untouched", v, FG2);
        end
        peek2(12, 0, v); check("d2_rd_x_oor", v, BG2);
        peek2(0, 6, v);  check("d2_rd_y_oor", v, BG2);
        peek2(15, 7, v); check("d2_rd_xy_oor", v, BG2);
        s2_wr_x = 11; s2_wr_y = 5; s2_wr_color = 0; s2_wr_valid = 1;
        step();
        s2_wr_valid = 0;
        peek2(11, 5, v); check("d2_corner_written", v, BG2);
        peek2(10, 5, v); check("d2_neighbour_kept", v, FG2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
